unified_bus_arbiter: RTL and testbench
======================================

Name: unified_bus_arbiter

Overview:
- Shares one memory bus between the core's instruction-fetch port and data port. This allows a single unified RAM to serve both text and data.
- Sits between riscv_core and the system memory/bus fabric.
- Supports pipelined reads with in-order responses. A tag FIFO records which requester owns each outstanding read, so each response is routed back to its owner.

Parameters:
- MAX_OUTSTANDING, 4, maximum reads issued but not yet answered; power of two, at least 2.

Ports:
- clock  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- inst_address  in  32  fetch address (pc)
- inst_read_enable  in  1  fetch request
- inst_wait_req  out  1  fetch request not accepted this cycle
- inst_valid  out  1  fetch data valid
- inst_data  out  32  fetched word
- data_address  in  32  data address
- data_read_enable  in  1  load request
- data_write_enable  in  1  store request
- data_byte_enable  in  4  store/load lanes
- data_write_data  in  32  store data
- data_wait_req  out  1  data request not accepted this cycle
- data_valid  out  1  load data valid
- data_read_data  out  32  load data
- mem_address  out  32  bus address
- mem_read  out  1  bus read command
- mem_write  out  1  bus write command
- mem_byte_enable  out  4  bus lanes
- mem_write_data  out  32  bus write data
- mem_wait_req  in  1  bus stall; command not accepted
- mem_read_data  in  32  bus read data
- mem_read_data_valid  in  1  read response strobe, in order
- protocol_error  out  1  sticky flag: a response arrived with no read outstanding

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset is asynchronous and active-high.
  - While in reset: tag FIFO empty, count 0, protocol_error 0, last-grant register = INST.
- Request and grant:
  - Data request = data_read_enable | data_write_enable.
  - Instruction request = inst_read_enable.
  - Default grant priority: data over instruction.
  - Grant is combinational in the same cycle.
  - The granted requester's address, command, byte enables and write data drive the mem_* outputs combinationally.
  - With no request, mem_read = mem_write = 0 and the other mem_* outputs are don't-care (driven 0).
  - data_read_enable and data_write_enable both high is illegal. Write wins and protocol_error is NOT set.
  - Instruction fetch is always a read with mem_byte_enable = 4'hF.
- Acceptance:
  - A command is accepted when it is granted, mem_wait_req = 0, and (for reads) the FIFO is not full or a pop occurs in the same cycle.
  - The acceptance condition gates mem_read: when the FIFO is full with no pop, mem_read = 0.
  - Ungranted or unaccepted requesters see wait_req = 1 and must hold their request stable.
- Tag FIFO:
  - Each accepted read pushes a 1-bit requester ID; writes push nothing.
  - On mem_read_data_valid, the head is popped and mem_read_data is routed combinationally (zero latency) to the owning port, with that port's valid asserted for exactly that cycle.
  - The other port's valid stays 0; its data output is don't-care (driven 0).
  - Simultaneous push and pop: count unchanged; allowed even when full.
  - Pointers wrap modulo MAX_OUTSTANDING.
- protocol_error: mem_read_data_valid with count = 0 sets protocol_error until reset. The response is dropped and both valids stay 0.
- Latency: minimum read latency equals the bus latency. The arbiter adds zero cycles of command or response latency.
- Reset mid-transaction: FIFO flushed. The memory fabric shares this reset, so no stale responses are expected.

Optional Feature:
- Macro: UNIFIED_BUS_ARBITER_ROUND_ROBIN_EN.
- Defined:
  - On a same-cycle conflict, grant goes to the requester not granted on the last accepted command.
  - The last-grant register updates only when a command is accepted.
  - A held, stalled request keeps its grant until accepted.
- Undefined: fixed data-over-instruction priority; the last-grant register is not implemented.

Decomposition:
- Shared package: requester ID enum (REQ_INST = 1'b0, REQ_DATA = 1'b1).
- Sub-module bus_tag_fifo:
  - Parameterised depth and width.
  - Provides push, pop, full, empty, head and count.
  - Asynchronous reset.
- The arbiter top holds grant logic, response routing and the error flag.

Test Plan:
- Fetch only, mem_wait_req = 0, response 2 cycles later with 32'h00000013 -> inst_wait_req 0 on issue; inst_valid = 1 with inst_data = 32'h00000013 exactly 2 cycles later; data_valid 0.
- Same-cycle load and fetch conflict, fixed priority -> mem_address = data_address; inst_wait_req = 1 that cycle; fetch issued next cycle; responses routed data first, then inst.
- Four fetches back-to-back, no responses (MAX_OUTSTANDING = 4) -> fifth fetch sees inst_wait_req = 1 and mem_read = 0; response and new fetch in the same cycle -> accepted, count stays 4.
- Store of 32'hDEADBEEF with byte enable 4'b0011 under mem_wait_req = 1 for 3 cycles -> data_wait_req = 1 for 3 cycles, mem_write held; accepted in cycle 4; FIFO count unchanged.
- mem_read_data_valid pulse with FIFO empty -> protocol_error = 1 and stays 1; both valids 0; cleared only by reset.
- Round-robin build, continuous conflict for 4 cycles -> grants alternate DATA, INST, DATA, INST after reset (last-grant = INST).

Source files
------------

// File: rtl/unified_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : unified_bus_arbiter_pkg
// Brief    : Shared types and constants for the unified bus arbiter slice.
// Revision : 1.0 - initial release
// ============================================================================
package unified_bus_arbiter_pkg;

    // Identifies which core port owns a bus command or an outstanding read.
    typedef enum logic {
        REQ_INST = 1'b0,
        REQ_DATA = 1'b1
    } req_id_e;

    // Instruction fetches always read a full word.
    localparam logic [3:0] c_BE_WORD = 4'hF;

endpackage
`default_nettype wire

// File: rtl/unified_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : unified_bus_arbiter_if
// Brief    : Core-side fetch/data ports and memory-side bus of the arbiter.
//            The slave modport is the arbiter's view; master is the view of
//            the core plus memory fabric that surrounds it.
// Revision : 1.0 - initial release
// ============================================================================
interface unified_bus_arbiter_if;

    logic [31:0] inst_address;
    logic        inst_read_enable;
    logic        inst_wait_req;
    logic        inst_valid;
    logic [31:0] inst_data;

    logic [31:0] data_address;
    logic        data_read_enable;
    logic        data_write_enable;
    logic [3:0]  data_byte_enable;
    logic [31:0] data_write_data;
    logic        data_wait_req;
    logic        data_valid;
    logic [31:0] data_read_data;

    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_write_data;
    logic        mem_wait_req;
    logic [31:0] mem_read_data;
    logic        mem_read_data_valid;

    logic        protocol_error;

    modport slave (
        input  inst_address, inst_read_enable,
        output inst_wait_req, inst_valid, inst_data,
        input  data_address, data_read_enable, data_write_enable,
        input  data_byte_enable, data_write_data,
        output data_wait_req, data_valid, data_read_data,
        output mem_address, mem_read, mem_write, mem_byte_enable, mem_write_data,
        input  mem_wait_req, mem_read_data, mem_read_data_valid,
        output protocol_error
    );

    modport master (
        output inst_address, inst_read_enable,
        input  inst_wait_req, inst_valid, inst_data,
        output data_address, data_read_enable, data_write_enable,
        output data_byte_enable, data_write_data,
        input  data_wait_req, data_valid, data_read_data,
        input  mem_address, mem_read, mem_write, mem_byte_enable, mem_write_data,
        output mem_wait_req, mem_read_data, mem_read_data_valid,
        input  protocol_error
    );

endinterface
`default_nettype wire

// File: rtl/unified_bus_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bus_tag_fifo
// Brief    : Small circular FIFO recording the owner of each outstanding read.
//            DEPTH must be a power of two so the pointers wrap naturally.
//            Simultaneous push and pop is legal even when full.
// Revision : 1.0 - initial release
// ============================================================================
module bus_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  wire logic                     clock,
    input  wire logic                     reset,
    input  wire logic                     i_push,
    input  wire logic [WIDTH-1:0]         i_push_data,
    input  wire logic                     i_pop,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [WIDTH-1:0]              o_head,
    output logic [$clog2(DEPTH):0]        o_count
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]  c_FULL  = (c_PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Tag storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clock) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_full  = (r_count == c_FULL);
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/unified_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : unified_bus_arbiter
// Brief    : Shares one memory bus between the fetch port and the data port.
//            Zero-latency combinational grant and response routing; a tag
//            FIFO returns in-order read responses to their owners.
// Options  : UNIFIED_BUS_ARBITER_ROUND_ROBIN_EN - alternate grants on
//            conflict instead of fixed data-over-instruction priority.
// Revision : 1.0 - initial release
// ============================================================================
module unified_bus_arbiter
    import unified_bus_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  wire logic             clock,
    input  wire logic             reset,
    unified_bus_arbiter_if.slave  bus
);

    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING) + 1;

    logic               w_data_req;
    logic               w_inst_req;
    logic               w_grant_valid;
    req_id_e            w_grant_id;
    logic               w_is_read;
    logic               w_is_write;
    logic               w_can_read;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [0:0]         w_fifo_head;
    logic [c_CNT_W-1:0] w_fifo_count;
    req_id_e            w_head_id;
    logic               r_protocol_error;

    assign w_data_req    = bus.data_read_enable | bus.data_write_enable;
    assign w_inst_req    = bus.inst_read_enable;
    assign w_grant_valid = w_data_req | w_inst_req;

`ifdef UNIFIED_BUS_ARBITER_ROUND_ROBIN_EN
    req_id_e r_last_grant;
    logic    r_hold_valid;
    req_id_e r_hold_id;

    // Remember the last accepted owner, and any grant left stalled by the bus.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_grant <= REQ_INST;
            r_hold_valid <= 1'b0;
            r_hold_id    <= REQ_INST;
        end else begin
            if (w_accept) r_last_grant <= w_grant_id;
            r_hold_valid <= w_grant_valid & ~w_accept;
            r_hold_id    <= w_grant_id;
        end
    end

    // Stalled grant sticks; otherwise a conflict goes to the other requester.
    always_comb begin
        w_grant_id = REQ_INST;
        if (r_hold_valid && ((r_hold_id == REQ_DATA && w_data_req) ||
                             (r_hold_id == REQ_INST && w_inst_req))) begin
            w_grant_id = r_hold_id;
        end else if (w_data_req && w_inst_req) begin
            w_grant_id = (r_last_grant == REQ_INST) ? REQ_DATA : REQ_INST;
        end else if (w_data_req) begin
            w_grant_id = REQ_DATA;
        end
    end
`else
    // Fixed priority: data port wins every conflict.
    always_comb begin
        w_grant_id = REQ_INST;
        if (w_data_req) w_grant_id = REQ_DATA;
    end
`endif

    // Steer the granted requester onto the bus; a store beats a load if both set.
    always_comb begin
        bus.mem_address     = '0;
        bus.mem_byte_enable = '0;
        bus.mem_write_data  = '0;
        w_is_read           = 1'b0;
        w_is_write          = 1'b0;
        if (w_grant_valid) begin
            if (w_grant_id == REQ_DATA) begin
                bus.mem_address     = bus.data_address;
                bus.mem_byte_enable = bus.data_byte_enable;
                bus.mem_write_data  = bus.data_write_data;
                w_is_write          = bus.data_write_enable;
                w_is_read           = ~bus.data_write_enable;
            end else begin
                bus.mem_address     = bus.inst_address;
                bus.mem_byte_enable = c_BE_WORD;
                w_is_read           = 1'b1;
            end
        end
    end

    // A read may issue into a full FIFO only when a response frees a slot now.
    assign w_pop      = bus.mem_read_data_valid & ~w_fifo_empty;
    assign w_can_read = ~w_fifo_full | w_pop;
    assign w_accept   = w_grant_valid & ~bus.mem_wait_req & (w_is_write | w_can_read);
    assign w_push     = w_accept & w_is_read;

    assign bus.mem_read      = w_is_read & w_can_read;
    assign bus.mem_write     = w_is_write;
    assign bus.inst_wait_req = w_inst_req & ~(w_accept & (w_grant_id == REQ_INST));
    assign bus.data_wait_req = w_data_req & ~(w_accept & (w_grant_id == REQ_DATA));

    bus_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_tag_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (1'(w_grant_id)),
        .i_pop       (w_pop),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_head      (w_fifo_head),
        .o_count     (w_fifo_count)
    );

    // Route each response to the owner recorded at the FIFO head.
    assign w_head_id           = req_id_e'(w_fifo_head);
    assign bus.inst_valid      = w_pop & (w_head_id == REQ_INST);
    assign bus.data_valid      = w_pop & (w_head_id == REQ_DATA);
    assign bus.inst_data       = bus.inst_valid ? bus.mem_read_data : '0;
    assign bus.data_read_data  = bus.data_valid ? bus.mem_read_data : '0;

    // Sticky flag for a response that arrives with nothing outstanding.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_protocol_error <= 1'b0;
        end else if (bus.mem_read_data_valid && (w_fifo_count == '0)) begin
            r_protocol_error <= 1'b1;
        end
    end

    assign bus.protocol_error = r_protocol_error;

endmodule
`default_nettype wire

// File: tb/tb_unified_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_unified_bus_arbiter
// Brief    : Self-checking bench: directed scenarios plus a randomized run
//            compared against a queue-based owner model.
// Options  : UNIFIED_BUS_ARBITER_ROUND_ROBIN_EN selects alternating grants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unified_bus_arbiter;
    import unified_bus_arbiter_pkg::*;

    localparam int MAX_OUT = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    unified_bus_arbiter_if bus ();

    unified_bus_arbiter #(.MAX_OUTSTANDING(MAX_OUT)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic idle_inputs();
        bus.inst_address        = '0;
        bus.inst_read_enable    = 1'b0;
        bus.data_address        = '0;
        bus.data_read_enable    = 1'b0;
        bus.data_write_enable   = 1'b0;
        bus.data_byte_enable    = '0;
        bus.data_write_data     = '0;
        bus.mem_wait_req        = 1'b0;
        bus.mem_read_data       = '0;
        bus.mem_read_data_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        tick();
        checks++;
        if ({bus.protocol_error, bus.mem_read, bus.mem_write, bus.inst_valid, bus.data_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs actual=%b required=00000",
                     {bus.protocol_error, bus.mem_read, bus.mem_write, bus.inst_valid, bus.data_valid});
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        bus.inst_read_enable = 1'b1;
        bus.inst_address     = 32'h0000_0100;
        #4;
        checks++;
        if ({bus.inst_wait_req, bus.mem_read, bus.mem_address, bus.mem_byte_enable} !== {1'b0, 1'b1, 32'h100, 4'hF}) begin
            failures++;
            $display("FAIL fetch_issue actual=%b/%b/%h/%h required=0/1/00000100/f",
                     bus.inst_wait_req, bus.mem_read, bus.mem_address, bus.mem_byte_enable);
        end
        tick();
        bus.inst_read_enable = 1'b0;
        #4;
        checks++;
        if (bus.inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL fetch_early_valid actual=%b required=0", bus.inst_valid);
        end
        tick();
        bus.mem_read_data_valid = 1'b1;
        bus.mem_read_data       = 32'h0000_0013;
        #4;
        checks++;
        if ({bus.inst_valid, bus.inst_data, bus.data_valid} !== {1'b1, 32'h13, 1'b0}) begin
            failures++;
            $display("FAIL fetch_response actual=%b/%h/%b required=1/00000013/0",
                     bus.inst_valid, bus.inst_data, bus.data_valid);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_conflict();
        bus.inst_read_enable = 1'b1;
        bus.inst_address     = 32'h0000_0200;
        bus.data_read_enable = 1'b1;
        bus.data_address     = 32'h8000_0040;
        bus.data_byte_enable = 4'hF;
        #4;
        checks++;
        if ({bus.mem_address, bus.inst_wait_req, bus.data_wait_req, bus.mem_read} !== {32'h8000_0040, 1'b1, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL conflict_grant actual=%h/%b/%b/%b required=80000040/1/0/1",
                     bus.mem_address, bus.inst_wait_req, bus.data_wait_req, bus.mem_read);
        end
        tick();
        bus.data_read_enable = 1'b0;
        #4;
        checks++;
        if ({bus.mem_address, bus.inst_wait_req} !== {32'h0000_0200, 1'b0}) begin
            failures++;
            $display("FAIL conflict_fetch_next actual=%h/%b required=00000200/0",
                     bus.mem_address, bus.inst_wait_req);
        end
        tick();
        bus.inst_read_enable    = 1'b0;
        bus.mem_read_data_valid = 1'b1;
        bus.mem_read_data       = 32'hAAAA_0001;
        #4;
        checks++;
        if ({bus.data_valid, bus.data_read_data, bus.inst_valid} !== {1'b1, 32'hAAAA_0001, 1'b0}) begin
            failures++;
            $display("FAIL conflict_resp_data actual=%b/%h/%b required=1/aaaa0001/0",
                     bus.data_valid, bus.data_read_data, bus.inst_valid);
        end
        tick();
        bus.mem_read_data = 32'hBBBB_0002;
        #4;
        checks++;
        if ({bus.inst_valid, bus.inst_data, bus.data_valid} !== {1'b1, 32'hBBBB_0002, 1'b0}) begin
            failures++;
            $display("FAIL conflict_resp_inst actual=%b/%h/%b required=1/bbbb0002/0",
                     bus.inst_valid, bus.inst_data, bus.data_valid);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_fifo_full();
        bus.inst_read_enable = 1'b1;
        for (int i = 0; i < MAX_OUT; i++) begin
            bus.inst_address = 32'h1000 + 32'(4 * i);
            #4;
            checks++;
            if ({bus.inst_wait_req, bus.mem_read} !== 2'b01) begin
                failures++;
                $display("FAIL full_fill_%0d actual=%b/%b required=0/1", i, bus.inst_wait_req, bus.mem_read);
            end
            tick();
        end
        bus.inst_address = 32'h1010;
        #4;
        checks++;
        if ({bus.inst_wait_req, bus.mem_read} !== 2'b10) begin
            failures++;
            $display("FAIL full_blocked actual=%b/%b required=1/0", bus.inst_wait_req, bus.mem_read);
        end
        tick();
        bus.mem_read_data_valid = 1'b1;
        bus.mem_read_data       = 32'h5555_0000;
        #4;
        checks++;
        if ({bus.inst_wait_req, bus.mem_read, bus.inst_valid, bus.inst_data} !== {1'b0, 1'b1, 1'b1, 32'h5555_0000}) begin
            failures++;
            $display("FAIL full_push_pop actual=%b/%b/%b/%h required=0/1/1/55550000",
                     bus.inst_wait_req, bus.mem_read, bus.inst_valid, bus.inst_data);
        end
        tick();
        bus.mem_read_data_valid = 1'b0;
        bus.inst_address        = 32'h1014;
        #4;
        checks++;
        if ({bus.inst_wait_req, bus.mem_read} !== 2'b10) begin
            failures++;
            $display("FAIL full_still_full actual=%b/%b required=1/0", bus.inst_wait_req, bus.mem_read);
        end
        tick();
        bus.inst_read_enable    = 1'b0;
        bus.mem_read_data_valid = 1'b1;
        for (int i = 0; i < MAX_OUT; i++) begin
            bus.mem_read_data = 32'h6000 + 32'(i);
            #4;
            checks++;
            if ({bus.inst_valid, bus.inst_data} !== {1'b1, 32'h6000 + 32'(i)}) begin
                failures++;
                $display("FAIL full_drain_%0d actual=%b/%h required=1/%h",
                         i, bus.inst_valid, bus.inst_data, 32'h6000 + 32'(i));
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_store_stall();
        bus.data_write_enable = 1'b1;
        bus.data_address      = 32'h0000_3000;
        bus.data_write_data   = 32'hDEAD_BEEF;
        bus.data_byte_enable  = 4'b0011;
        bus.mem_wait_req      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #4;
            checks++;
            if ({bus.data_wait_req, bus.mem_write, bus.mem_read, bus.mem_write_data, bus.mem_byte_enable, bus.mem_address}
                !== {1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'b0011, 32'h3000}) begin
                failures++;
                $display("FAIL store_stall_%0d actual=%b/%b/%b/%h/%h/%h required=1/1/0/deadbeef/3/00003000", i,
                         bus.data_wait_req, bus.mem_write, bus.mem_read, bus.mem_write_data,
                         bus.mem_byte_enable, bus.mem_address);
            end
            tick();
        end
        bus.mem_wait_req = 1'b0;
        #4;
        checks++;
        if ({bus.data_wait_req, bus.mem_write} !== 2'b01) begin
            failures++;
            $display("FAIL store_accept actual=%b/%b required=0/1", bus.data_wait_req, bus.mem_write);
        end
        tick();
        bus.data_read_enable = 1'b1;
        #4;
        checks++;
        if ({bus.mem_write, bus.mem_read, bus.data_wait_req} !== 3'b100) begin
            failures++;
            $display("FAIL store_and_load actual=%b/%b/%b required=1/0/0",
                     bus.mem_write, bus.mem_read, bus.data_wait_req);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_protocol_error();
        #4;
        checks++;
        if (bus.protocol_error !== 1'b0) begin
            failures++;
            $display("FAIL perr_before actual=%b required=0", bus.protocol_error);
        end
        tick();
        bus.mem_read_data_valid = 1'b1;
        bus.mem_read_data       = 32'h0000_0077;
        #4;
        checks++;
        if ({bus.inst_valid, bus.data_valid} !== 2'b00) begin
            failures++;
            $display("FAIL perr_valids actual=%b/%b required=0/0", bus.inst_valid, bus.data_valid);
        end
        tick();
        bus.mem_read_data_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #4;
            checks++;
            if (bus.protocol_error !== 1'b1) begin
                failures++;
                $display("FAIL perr_sticky_%0d actual=%b required=1", i, bus.protocol_error);
            end
            tick();
        end
        reset = 1'b1;
        #2;
        checks++;
        if (bus.protocol_error !== 1'b0) begin
            failures++;
            $display("FAIL perr_cleared actual=%b required=0", bus.protocol_error);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_grant_sequence();
        int exp_owner [4];
`ifdef UNIFIED_BUS_ARBITER_ROUND_ROBIN_EN
        exp_owner = '{1, 0, 1, 0};
`else
        exp_owner = '{1, 1, 1, 1};
`endif
        bus.inst_read_enable = 1'b1;
        bus.inst_address     = 32'h0000_0400;
        bus.data_read_enable = 1'b1;
        bus.data_address     = 32'h0000_0500;
        bus.data_byte_enable = 4'hF;
        for (int i = 0; i < 4; i++) begin
            #4;
            checks++;
            if (bus.mem_address !== ((exp_owner[i] == 1) ? 32'h500 : 32'h400)) begin
                failures++;
                $display("FAIL grant_seq_%0d actual=%h required=%h", i, bus.mem_address,
                         (exp_owner[i] == 1) ? 32'h500 : 32'h400);
            end
            tick();
        end
        idle_inputs();
        bus.mem_read_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.mem_read_data = 32'h9000 + 32'(i);
            #4;
            checks++;
            if ({bus.data_valid, bus.inst_valid} !== ((exp_owner[i] == 1) ? 2'b10 : 2'b01)) begin
                failures++;
                $display("FAIL grant_route_%0d actual=%b%b required=%b", i, bus.data_valid, bus.inst_valid,
                         (exp_owner[i] == 1) ? 2'b10 : 2'b01);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int          q[$];
        int          last_owner;
        bit          hold_valid;
        int          hold_owner;
        bit          p_inst, p_data, p_rd, p_wr;
        logic [31:0] i_addr, d_addr, d_wd, r_data;
        logic [3:0]  d_be;
        int          g;
        bit          wait_req, resp, is_rd, is_wr, can_rd, acc;
        logic [5:0]  exp_flags, act_flags;

        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
        last_owner = 0;
        hold_valid = 1'b0;
        hold_owner = 0;
        p_inst = 1'b0;
        p_data = 1'b0;
        p_rd = 1'b0;
        p_wr = 1'b0;
        i_addr = '0;
        d_addr = '0;
        d_wd = '0;
        d_be = '0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!p_inst && $urandom_range(0, 99) < 50) begin
                p_inst = 1'b1;
                i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!p_data && $urandom_range(0, 99) < 40) begin
                int kind;
                kind   = $urandom_range(0, 9);
                p_data = 1'b1;
                p_rd   = (kind < 5) || (kind == 9);
                p_wr   = (kind >= 5);
                d_addr = $urandom;
                d_wd   = $urandom;
                d_be   = 4'($urandom_range(1, 15));
            end
            wait_req = ($urandom_range(0, 99) < 25);
            resp     = (q.size() > 0) && ($urandom_range(0, 99) < 45);
            r_data   = $urandom;

            bus.inst_read_enable    = p_inst;
            bus.inst_address        = i_addr;
            bus.data_read_enable    = p_data & p_rd;
            bus.data_write_enable   = p_data & p_wr;
            bus.data_address        = d_addr;
            bus.data_write_data     = d_wd;
            bus.data_byte_enable    = d_be;
            bus.mem_wait_req        = wait_req;
            bus.mem_read_data_valid = resp;
            bus.mem_read_data       = r_data;

            // Owner of this cycle's grant: -1 none, 0 fetch, 1 data.
            g = -1;
`ifdef UNIFIED_BUS_ARBITER_ROUND_ROBIN_EN
            if (hold_valid && ((hold_owner == 1 && p_data) || (hold_owner == 0 && p_inst)))
                g = hold_owner;
            else if (p_data && p_inst)
                g = 1 - last_owner;
            else if (p_data)
                g = 1;
            else if (p_inst)
                g = 0;
`else
            if (p_data)      g = 1;
            else if (p_inst) g = 0;
`endif
            is_wr  = (g == 1) && p_wr;
            is_rd  = (g == 0) || ((g == 1) && !p_wr);
            can_rd = (q.size() < MAX_OUT) || resp;
            acc    = (g >= 0) && !wait_req && (is_wr || can_rd);
            exp_flags = {is_rd && can_rd, is_wr,
                         p_inst && !(acc && g == 0), p_data && !(acc && g == 1),
                         resp && (q[0] == 0), resp && (q[0] == 1)};
            #4;
            act_flags = {bus.mem_read, bus.mem_write, bus.inst_wait_req, bus.data_wait_req,
                         bus.inst_valid, bus.data_valid};
            checks++;
            if (act_flags !== exp_flags) begin
                failures++;
                $display("FAIL rand_flags cyc=%0d actual=%b required=%b", cyc, act_flags, exp_flags);
            end
            if (g >= 0) begin
                checks++;
                if ({bus.mem_address, bus.mem_byte_enable} !== ((g == 1) ? {d_addr, d_be} : {i_addr, 4'hF})) begin
                    failures++;
                    $display("FAIL rand_cmd cyc=%0d actual=%h/%h required=%h/%h", cyc, bus.mem_address,
                             bus.mem_byte_enable, (g == 1) ? d_addr : i_addr, (g == 1) ? d_be : 4'hF);
                end
            end
            if (is_wr) begin
                checks++;
                if (bus.mem_write_data !== d_wd) begin
                    failures++;
                    $display("FAIL rand_wdata cyc=%0d actual=%h required=%h", cyc, bus.mem_write_data, d_wd);
                end
            end
            if (resp) begin
                checks++;
                if (((q[0] == 0) ? bus.inst_data : bus.data_read_data) !== r_data) begin
                    failures++;
                    $display("FAIL rand_rdata cyc=%0d actual=%h required=%h", cyc,
                             (q[0] == 0) ? bus.inst_data : bus.data_read_data, r_data);
                end
            end
            tick();
            if (resp) void'(q.pop_front());
            if (acc && is_rd) q.push_back(g);
            if (acc) begin
                last_owner = g;
                if (g == 1) p_data = 1'b0;
                else        p_inst = 1'b0;
            end
            hold_valid = (g >= 0) && !acc;
            hold_owner = g;
        end
        idle_inputs();
        checks++;
        if (bus.protocol_error !== 1'b0) begin
            failures++;
            $display("FAIL rand_perr actual=%b required=0", bus.protocol_error);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fetch();
        test_conflict();
        test_fifo_full();
        test_store_stall();
        test_protocol_error();
        test_grant_sequence();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
